// File: rtl/mips_pkg.sv
// Shared types and widths for the MIPS pipeline front end.
package mips_pkg;

   localparam int INSTR_W = 32;
   localparam int ADDR_W  = 32;
   localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0;

   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_unit_pc_reg.sv
// Program counter register: load a target, advance by PC_STEP, or hold.
module pc_reg
   import mips_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC = 32'd0,
   parameter logic [ADDR_W-1:0] PC_STEP  = 32'd4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load_i,
   input  logic              inc_i,
   input  logic [ADDR_W-1:0] load_addr_i,
   output logic [ADDR_W-1:0] pc_o,
   output logic [ADDR_W-1:0] pc_plus_step_o
);

   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] pc_d;

   assign pc_plus_step_o = pc_q + PC_STEP;
   assign pc_o           = pc_q;

   // Load has priority so a redirect overrides any pending increment.
   always_comb begin
      pc_d = pc_q;
      if (load_i) begin
         pc_d = load_addr_i;
      end else if (inc_i) begin
         pc_d = pc_plus_step_o;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: drives the instruction memory from the PC and fills the IF/ID
// register, with stall, redirect and end-of-program halt.
module instruction_fetch_unit
   import mips_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC = 32'd0,
   parameter logic [ADDR_W-1:0] END_ADDR = 32'd356,
   parameter logic [ADDR_W-1:0] PC_STEP  = 32'd4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               stall,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_addr,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic [INSTR_W-1:0] imem_data,
   output logic               if_id_valid,
   output logic [INSTR_W-1:0] if_id_instr,
   output logic [ADDR_W-1:0]  if_id_pc,
   output logic [ADDR_W-1:0]  if_id_pc_plus4,
   output logic               halted,
   output logic               misalign_err,
   output logic [31:0]        fetch_count
);

   fetch_state_t       state_q;
   logic               valid_q;
   logic [INSTR_W-1:0] instr_q;
   logic [ADDR_W-1:0]  ifPc_q;
   logic [ADDR_W-1:0]  ifPcPlus4_q;
   logic               misalign_q;
   logic [31:0]        count_q;

   logic [ADDR_W-1:0]  pc;
   logic [ADDR_W-1:0]  pcPlusStep;
   logic [ADDR_W-1:0]  redirectTarget;
   logic               pcInc;

   assign redirectTarget = {redirect_addr[ADDR_W-1:2], 2'b00};
   assign pcInc          = !redirect_valid && !stall && (state_q == RUN);

   pc_reg #(
      .RESET_PC(RESET_PC),
      .PC_STEP (PC_STEP)
   ) u_pc_reg (
      .clk           (clk),
      .reset         (reset),
      .load_i        (redirect_valid),
      .inc_i         (pcInc),
      .load_addr_i   (redirectTarget),
      .pc_o          (pc),
      .pc_plus_step_o(pcPlusStep)
   );

   // Redirect squashes IF/ID but leaves its pc fields as they were.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= RUN;
         valid_q     <= 1'b0;
         instr_q     <= NOP_INSTR;
         ifPc_q      <= '0;
         ifPcPlus4_q <= '0;
         misalign_q  <= 1'b0;
         count_q     <= '0;
      end else if (redirect_valid) begin
         valid_q <= 1'b0;
         instr_q <= NOP_INSTR;
         if (redirect_addr[1:0] != 2'b00) begin
            misalign_q <= 1'b1;
         end
         state_q <= (redirectTarget > END_ADDR) ? HALT : RUN;
      end else if (!stall) begin
         if (state_q == RUN) begin
            valid_q     <= 1'b1;
            instr_q     <= imem_data;
            ifPc_q      <= pc;
            ifPcPlus4_q <= pcPlusStep;
            count_q     <= count_q + 32'd1;
            if (pcPlusStep > END_ADDR) begin
               state_q <= HALT;
            end
         end else begin
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
         end
      end
   end

   assign imem_addr      = pc;
   assign if_id_valid    = valid_q;
   assign if_id_instr    = instr_q;
   assign if_id_pc       = ifPc_q;
   assign if_id_pc_plus4 = ifPcPlus4_q;
   assign halted         = (state_q == HALT);
   assign misalign_err   = misalign_q;
   assign fetch_count    = count_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scenario and randomized checks of instruction_fetch_unit against a behavioural fetch model.
module tb_instruction_fetch_unit;

   localparam logic [31:0] END_ADDR = 32'd356;

   logic        clk;
   logic        reset;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_addr;
   logic [31:0] imem_addr;
   logic [31:0] imem_data;
   logic        if_id_valid;
   logic [31:0] if_id_instr;
   logic [31:0] if_id_pc;
   logic [31:0] if_id_pc_plus4;
   logic        halted;
   logic        misalign_err;
   logic [31:0] fetch_count;

   int checks = 0;
   int fails  = 0;

   logic [31:0] mPc, mInstr, mIfPc, mIfPc4, mCount;
   logic        mHalted, mValid, mMis;

   instruction_fetch_unit dut (
      .clk           (clk),
      .reset         (reset),
      .stall         (stall),
      .redirect_valid(redirect_valid),
      .redirect_addr (redirect_addr),
      .imem_addr     (imem_addr),
      .imem_data     (imem_data),
      .if_id_valid   (if_id_valid),
      .if_id_instr   (if_id_instr),
      .if_id_pc      (if_id_pc),
      .if_id_pc_plus4(if_id_pc_plus4),
      .halted        (halted),
      .misalign_err  (misalign_err),
      .fetch_count   (fetch_count)
   );

   function automatic logic [31:0] memWord(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'h1234_5678;
   endfunction

   assign imem_data = memWord(imem_addr);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] timeout");
   end

   // One clock of the fetch rules: reset, then redirect, then stall, then normal.
   task automatic modelStep();
      logic [31:0] target;
      if (reset) begin
         mPc = 32'd0; mHalted = 1'b0; mValid = 1'b0; mInstr = 32'd0;
         mIfPc = 32'd0; mIfPc4 = 32'd0; mMis = 1'b0; mCount = 32'd0;
      end else if (redirect_valid) begin
         target = redirect_addr & 32'hFFFF_FFFC;
         if (redirect_addr % 4 != 0) mMis = 1'b1;
         mValid = 1'b0; mInstr = 32'd0;
         mPc = target;
         mHalted = (target > END_ADDR);
      end else if (stall) begin
         // everything holds
      end else if (!mHalted) begin
         mValid = 1'b1; mInstr = memWord(mPc);
         mIfPc = mPc; mIfPc4 = mPc + 32'd4;
         mCount = mCount + 32'd1;
         mHalted = ((mPc + 32'd4) > END_ADDR);
         mPc = mPc + 32'd4;
      end else begin
         mValid = 1'b0; mInstr = 32'd0;
      end
   endtask

   task automatic applyStimulus(input logic rs, input logic st, input logic rv, input logic [31:0] ra);
      reset = rs; stall = st; redirect_valid = rv; redirect_addr = ra;
      @(posedge clk);
      modelStep();
      #1;
   endtask

   task automatic test_reset();
      applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
      checks++; if (imem_addr !== 32'd0) begin fails++; $display("[TB] FAIL reset_pc: got %h expected %h", imem_addr, 32'd0); end
      checks++; if (if_id_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_valid: got %b expected 0", if_id_valid); end
      checks++; if (if_id_instr !== 32'd0) begin fails++; $display("[TB] FAIL reset_instr: got %h expected 0", if_id_instr); end
      checks++; if (if_id_pc !== 32'd0 || if_id_pc_plus4 !== 32'd0) begin fails++; $display("[TB] FAIL reset_ifpc: got %h/%h expected 0/0", if_id_pc, if_id_pc_plus4); end
      checks++; if (halted !== 1'b0 || misalign_err !== 1'b0) begin fails++; $display("[TB] FAIL reset_flags: got %b/%b expected 0/0", halted, misalign_err); end
      checks++; if (fetch_count !== 32'd0) begin fails++; $display("[TB] FAIL reset_count: got %0d expected 0", fetch_count); end
   endtask

   task automatic test_sequential();
      for (int k = 1; k <= 8; k++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
         checks++; if (imem_addr !== 32'(4 * k)) begin fails++; $display("[TB] FAIL seq_pc: got %0d expected %0d", imem_addr, 4 * k); end
         checks++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'(4 * (k - 1))) begin fails++; $display("[TB] FAIL seq_ifpc: got %b/%0d expected 1/%0d", if_id_valid, if_id_pc, 4 * (k - 1)); end
         checks++; if (if_id_instr !== memWord(32'(4 * (k - 1))) || if_id_pc_plus4 !== 32'(4 * k)) begin fails++; $display("[TB] FAIL seq_instr: got %h/%0d expected %h/%0d", if_id_instr, if_id_pc_plus4, memWord(32'(4 * (k - 1))), 4 * k); end
         checks++; if (fetch_count !== 32'(k)) begin fails++; $display("[TB] FAIL seq_count: got %0d expected %0d", fetch_count, k); end
      end
   endtask

   task automatic test_stall();
      applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
      for (int k = 0; k < 6; k++) applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
         checks++; if (imem_addr !== 32'd24) begin fails++; $display("[TB] FAIL stall_pc: got %0d expected 24", imem_addr); end
         checks++; if (if_id_pc !== 32'd20 || if_id_instr !== memWord(32'd20) || if_id_valid !== 1'b1) begin fails++; $display("[TB] FAIL stall_ifid: got pc %0d instr %h expected pc 20 instr %h", if_id_pc, if_id_instr, memWord(32'd20)); end
         checks++; if (fetch_count !== 32'd6) begin fails++; $display("[TB] FAIL stall_count: got %0d expected 6", fetch_count); end
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
      checks++; if (if_id_pc !== 32'd24 || imem_addr !== 32'd28 || fetch_count !== 32'd7) begin fails++; $display("[TB] FAIL stall_resume: got ifpc %0d pc %0d cnt %0d expected 24 28 7", if_id_pc, imem_addr, fetch_count); end
   endtask

   task automatic test_redirect();
      applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
      for (int k = 0; k < 12; k++) applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b1, 32'd120);
      checks++; if (imem_addr !== 32'd120) begin fails++; $display("[TB] FAIL redir_pc: got %0d expected 120", imem_addr); end
      checks++; if (if_id_valid !== 1'b0 || if_id_instr !== 32'd0 || if_id_pc !== 32'd44) begin fails++; $display("[TB] FAIL redir_squash: got %b/%h/%0d expected 0/0/44", if_id_valid, if_id_instr, if_id_pc); end
      checks++; if (fetch_count !== 32'd12) begin fails++; $display("[TB] FAIL redir_count: got %0d expected 12", fetch_count); end
      applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
      checks++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'd120 || if_id_instr !== memWord(32'd120)) begin fails++; $display("[TB] FAIL redir_target: got %b/%0d/%h expected 1/120/%h", if_id_valid, if_id_pc, if_id_instr, memWord(32'd120)); end
   endtask

   task automatic test_run_to_end();
      for (int i = 0; i < 100 && imem_addr !== 32'd356; i++) applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
      checks++; if (imem_addr !== 32'd356) begin fails++; $display("[TB] FAIL end_reach: got %0d expected 356", imem_addr); end
      applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
      checks++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'd356 || if_id_pc_plus4 !== 32'd360) begin fails++; $display("[TB] FAIL end_last: got %b/%0d/%0d expected 1/356/360", if_id_valid, if_id_pc, if_id_pc_plus4); end
      checks++; if (halted !== 1'b1 || imem_addr !== 32'd360) begin fails++; $display("[TB] FAIL end_halt: got %b/%0d expected 1/360", halted, imem_addr); end
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
         checks++; if (if_id_valid !== 1'b0 || if_id_instr !== 32'd0 || imem_addr !== 32'd360 || halted !== 1'b1) begin fails++; $display("[TB] FAIL end_frozen: got %b/%h/%0d/%b expected 0/0/360/1", if_id_valid, if_id_instr, imem_addr, halted); end
         checks++; if (fetch_count !== mCount) begin fails++; $display("[TB] FAIL end_count: got %0d expected %0d", fetch_count, mCount); end
      end
   endtask

   task automatic test_misaligned_redirect();
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h8A);
      checks++; if (imem_addr !== 32'h88 || halted !== 1'b0) begin fails++; $display("[TB] FAIL mis_pc: got %h/%b expected 88/0", imem_addr, halted); end
      checks++; if (misalign_err !== 1'b1) begin fails++; $display("[TB] FAIL mis_flag: got %b expected 1", misalign_err); end
      for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
      checks++; if (misalign_err !== 1'b1 || if_id_pc !== 32'h90 || if_id_valid !== 1'b1) begin fails++; $display("[TB] FAIL mis_sticky: got %b/%h/%b expected 1/90/1", misalign_err, if_id_pc, if_id_valid); end
   endtask

   task automatic test_stall_redirect_reset();
      applyStimulus(1'b0, 1'b1, 1'b1, 32'd200);
      checks++; if (imem_addr !== 32'd200 || if_id_valid !== 1'b0) begin fails++; $display("[TB] FAIL stallredir: got %0d/%b expected 200/0", imem_addr, if_id_valid); end
      applyStimulus(1'b0, 1'b0, 1'b1, 32'd400);
      checks++; if (halted !== 1'b1 || imem_addr !== 32'd400) begin fails++; $display("[TB] FAIL redir_beyond: got %b/%0d expected 1/400", halted, imem_addr); end
      applyStimulus(1'b0, 1'b0, 1'b1, 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
      checks++; if (imem_addr !== 32'd0 || if_id_valid !== 1'b0 || if_id_pc !== 32'd0 || if_id_pc_plus4 !== 32'd0) begin fails++; $display("[TB] FAIL midreset_ifid: got %0d/%b/%0d/%0d expected 0/0/0/0", imem_addr, if_id_valid, if_id_pc, if_id_pc_plus4); end
      checks++; if (misalign_err !== 1'b0 || halted !== 1'b0 || fetch_count !== 32'd0) begin fails++; $display("[TB] FAIL midreset_flags: got %b/%b/%0d expected 0/0/0", misalign_err, halted, fetch_count); end
   endtask

   task automatic test_random();
      logic rs, st, rv;
      logic [31:0] ra;
      for (int i = 0; i < 600; i++) begin
         rs = ($urandom_range(0, 99) < 2);
         st = ($urandom_range(0, 99) < 25);
         rv = ($urandom_range(0, 99) < 6);
         ra = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 380));
         applyStimulus(rs, st, rv, ra);
         checks++; if (imem_addr !== mPc) begin fails++; $display("[TB] FAIL rnd_pc: got %h expected %h", imem_addr, mPc); end
         checks++; if (if_id_valid !== mValid || if_id_instr !== mInstr) begin fails++; $display("[TB] FAIL rnd_instr: got %b/%h expected %b/%h", if_id_valid, if_id_instr, mValid, mInstr); end
         checks++; if (if_id_pc !== mIfPc || if_id_pc_plus4 !== mIfPc4) begin fails++; $display("[TB] FAIL rnd_ifpc: got %h/%h expected %h/%h", if_id_pc, if_id_pc_plus4, mIfPc, mIfPc4); end
         checks++; if (halted !== mHalted || misalign_err !== mMis) begin fails++; $display("[TB] FAIL rnd_flags: got %b/%b expected %b/%b", halted, misalign_err, mHalted, mMis); end
         checks++; if (fetch_count !== mCount) begin fails++; $display("[TB] FAIL rnd_count: got %0d expected %0d", fetch_count, mCount); end
      end
   endtask

   initial begin
      reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_addr = 32'd0;
      test_reset();
      test_sequential();
      test_stall();
      test_redirect();
      test_run_to_end();
      test_misaligned_redirect();
      test_stall_redirect_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
